// File: rtl/command_uart_tx.sv
// Six-button command transmitter: rising edges queue ASCII command codes that are sent as UART 8N1.
// Optional typematic repeat is compiled in with `define CMD_REPEAT_EN.
module command_uart_tx #(
  parameter int unsigned CLKS_PER_BIT  = 868,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Up,
  input  logic       Down,
  input  logic       Left,
  input  logic       Right,
  input  logic       Reset,
  input  logic       userStart,
  output logic       tx,
  output logic       busy,
  output logic [7:0] scancode,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_rep_check
    $error("REPEAT_CYCLES must be at least 1");
  end

  // Bit order: 0 Up, 1 Down, 2 Left, 3 Right, 4 Reset, 5 userStart.
  logic [5:0] btn;
  logic [5:0] prev_q;
  logic [5:0] rise;
  logic [5:0] set_req;
  logic [5:0] clr;
  logic [5:0] pending_q, pending_d;
  logic [5:0] sel;
  logic [7:0] sel_code;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    scancode_q, scancode_d;
  logic          tx_q, tx_d;

  assign btn  = {userStart, Reset, Right, Left, Down, Up};
  assign rise = btn & ~prev_q;

`ifdef CMD_REPEAT_EN
  localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  // A counter only arms on a real edge, so a button held through reset never repeats.
  logic [5:0]    armed_q;
  logic [RW-1:0] rep_cnt_q [6];
  logic [5:0]    rep_fire;

  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < 6; i++) begin
      rep_fire[i] = armed_q[i] & btn[i] & (rep_cnt_q[i] == REP_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= '0;
      for (int i = 0; i < 6; i++) begin
        rep_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (!btn[i]) begin
          armed_q[i]   <= 1'b0;
          rep_cnt_q[i] <= '0;
        end else if (rise[i]) begin
          armed_q[i]   <= 1'b1;
          rep_cnt_q[i] <= '0;
        end else if (armed_q[i]) begin
          if (rep_cnt_q[i] == REP_LAST) begin
            rep_cnt_q[i] <= '0;
          end else begin
            rep_cnt_q[i] <= rep_cnt_q[i] + RW'(1);
          end
        end
      end
    end
  end

  assign set_req = rise | rep_fire;
`else
  assign set_req = rise;
`endif

  // Fixed priority: Reset > userStart > Up > Down > Left > Right.
  always_comb begin
    sel      = '0;
    sel_code = 8'h00;
    if (pending_q[4]) begin
      sel[4]   = 1'b1;
      sel_code = 8'h72;
    end else if (pending_q[5]) begin
      sel[5]   = 1'b1;
      sel_code = 8'h71;
    end else if (pending_q[0]) begin
      sel[0]   = 1'b1;
      sel_code = 8'h77;
    end else if (pending_q[1]) begin
      sel[1]   = 1'b1;
      sel_code = 8'h73;
    end else if (pending_q[2]) begin
      sel[2]   = 1'b1;
      sel_code = 8'h61;
    end else if (pending_q[3]) begin
      sel[3]   = 1'b1;
      sel_code = 8'h64;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    scancode_d = scancode_q;
    tx_d       = tx_q;
    clr        = '0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (|pending_q) begin
          shift_d    = sel_code;
          scancode_d = sel_code;
          clr        = sel;
          baud_d     = '0;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    // A fresh edge on the bit being loaded keeps it pending.
    pending_d = (pending_q & ~clr) | set_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      scancode_q <= 8'h00;
      tx_q       <= 1'b1;
      pending_q  <= '0;
      prev_q     <= '1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      scancode_q <= scancode_d;
      tx_q       <= tx_d;
      pending_q  <= pending_d;
      prev_q     <= btn;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign scancode = scancode_q;
  assign done     = (state_q == STOP) && (baud_q == BAUD_LAST);

endmodule

// File: tb/tb_command_uart_tx.sv
// Bench for command_uart_tx: directed scenarios plus random button traffic against a
// transaction-level model (priority queue of pending commands, 41-cycle transmitter slot).
module tb_command_uart_tx;

  localparam int CPB = 4;
  localparam int REP = 100;
  localparam int SLOT = 10 * CPB + 1;
`ifdef CMD_REPEAT_EN
  localparam int EXP_REP = 4;
`else
  localparam int EXP_REP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic Up = 1'b0, Down = 1'b0, Left = 1'b0, Right = 1'b0, Reset = 1'b0, userStart = 1'b0;
  logic tx, busy, done;
  logic [7:0] scancode;

  int errors = 0;
  int checks = 0;

  command_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Up       (Up),
    .Down     (Down),
    .Left     (Left),
    .Right    (Right),
    .Reset    (Reset),
    .userStart(userStart),
    .tx       (tx),
    .busy     (busy),
    .scancode (scancode),
    .done     (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         edge_no = 0;
  bit [5:0]   m_prev = '1;
  bit [5:0]   m_pend = '0;
  bit [5:0]   m_b, m_rise;
  int         m_free = 0;
  int         m_since [6];
  bit         m_picked;
  int         prio_tab [6] = '{4, 5, 0, 1, 2, 3};
  logic [7:0] code_tab [6] = '{8'h77, 8'h73, 8'h61, 8'h64, 8'h72, 8'h71};
  logic [7:0] exp_q[$];
  int         exp_start_q[$];

  initial for (int i = 0; i < 6; i++) m_since[i] = -1;

  always @(posedge clk) begin
    edge_no = edge_no + 1;
    m_b = {userStart, Reset, Right, Left, Down, Up};
    if (rst) begin
      m_prev = '1;
      m_pend = '0;
      m_free = 0;
      for (int i = 0; i < 6; i++) m_since[i] = -1;
    end else begin
      if (edge_no >= m_free && m_pend != 0) begin
        m_picked = 1'b0;
        for (int p = 0; p < 6; p++) begin
          if (!m_picked && m_pend[prio_tab[p]]) begin
            m_picked = 1'b1;
            exp_q.push_back(code_tab[prio_tab[p]]);
            exp_start_q.push_back(edge_no);
            m_pend[prio_tab[p]] = 1'b0;
            m_free = edge_no + SLOT;
          end
        end
      end
      m_rise = m_b & ~m_prev;
      m_pend = m_pend | m_rise;
`ifdef CMD_REPEAT_EN
      for (int i = 0; i < 6; i++) begin
        if (!m_b[i]) m_since[i] = -1;
        else if (m_rise[i]) m_since[i] = 0;
        else if (m_since[i] >= 0) begin
          m_since[i] = m_since[i] + 1;
          if (m_since[i] % REP == 0) m_pend[i] = 1'b1;
        end
      end
`endif
      m_prev = m_b;
    end
  end

  // ---------------- line monitor ----------------
  bit         mon_in_frame = 1'b0;
  int         mon_n;
  int         mon_start;
  bit         mon_ok;
  logic       mon_s [40];
  logic [7:0] mon_byte;
  int         done_cnt = 0, busy_bad = 0, stray_done = 0;
  logic [7:0] got_byte_q[$];
  logic [7:0] got_sc_q[$];
  int         got_start_q[$];
  bit         got_ok_q[$];

  always @(negedge clk) begin
    if (rst) begin
      mon_in_frame = 1'b0;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (!mon_in_frame) begin
        if (tx === 1'b0) begin
          mon_in_frame = 1'b1;
          mon_n = 0;
          mon_start = edge_no;
          mon_ok = 1'b1;
        end else begin
          if (busy !== 1'b0) busy_bad++;
          if (done !== 1'b0) stray_done++;
        end
      end
      if (mon_in_frame) begin
        mon_s[mon_n] = tx;
        if (done !== ((mon_n == 39) ? 1'b1 : 1'b0)) mon_ok = 1'b0;
        if (busy !== 1'b1) mon_ok = 1'b0;
        if (mon_n == 39) begin
          for (int j = 0; j < 4; j++) if (mon_s[j] !== 1'b0) mon_ok = 1'b0;
          for (int j = 36; j < 40; j++) if (mon_s[j] !== 1'b1) mon_ok = 1'b0;
          for (int d = 0; d < 8; d++) begin
            mon_byte[d] = mon_s[4 + 4 * d];
            for (int t = 1; t < 4; t++) if (mon_s[4 + 4 * d + t] !== mon_s[4 + 4 * d]) mon_ok = 1'b0;
          end
          got_byte_q.push_back(mon_byte);
          got_sc_q.push_back(scancode);
          got_start_q.push_back(mon_start);
          got_ok_q.push_back(mon_ok);
          mon_in_frame = 1'b0;
        end
        mon_n++;
      end
    end
  end

  // ---------------- helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    got_byte_q.delete();
    got_sc_q.delete();
    got_start_q.delete();
    got_ok_q.delete();
    exp_q.delete();
    exp_start_q.delete();
    done_cnt = 0;
    busy_bad = 0;
    stray_done = 0;
  endtask

  task automatic wait_drain(output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (busy === 1'b0 && !mon_in_frame && m_pend == 0 && edge_no >= m_free) quiet++;
      else quiet = 0;
      if (quiet >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (scancode !== 8'h00) begin errors++; $display("FAIL reset_scancode: got %h want 00", scancode); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    repeat (5) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_quiet: busy %b want 0", busy); end
  endtask

  task automatic test_single_up();
    int k;
    bit ok;
    flush();
    k = edge_no;
    Up = 1'b1;
    tick();
    Up = 1'b0;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_drain: timeout"); end
    checks++; if (got_byte_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", got_byte_q.size()); end
    if (got_byte_q.size() >= 1) begin
      checks++; if (got_byte_q[0] !== 8'h77) begin errors++; $display("FAIL single_byte: got %h want 77", got_byte_q[0]); end
      checks++; if (got_start_q[0] != k + 2) begin errors++; $display("FAIL single_latency: start %0d want %0d", got_start_q[0], k + 2); end
      checks++; if (!got_ok_q[0]) begin errors++; $display("FAIL single_shape: frame timing bad, want clean 8N1"); end
      checks++; if (got_sc_q[0] !== 8'h77) begin errors++; $display("FAIL single_scancode: got %h want 77", got_sc_q[0]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done: got %0d pulses want 1", done_cnt); end
    checks++; if (busy_bad != 0 || stray_done != 0) begin errors++; $display("FAIL single_idle: busy_bad %0d stray_done %0d want 0", busy_bad, stray_done); end
  endtask

  task automatic test_priority();
    int k;
    bit ok;
    logic [7:0] want [3];
    want = '{8'h72, 8'h77, 8'h61};
    flush();
    k = edge_no;
    Up = 1'b1; Left = 1'b1; Reset = 1'b1;
    tick();
    Up = 1'b0; Left = 1'b0; Reset = 1'b0;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_drain: timeout"); end
    checks++; if (got_byte_q.size() != 3) begin errors++; $display("FAIL prio_count: got %0d want 3", got_byte_q.size()); end
    for (int i = 0; i < 3 && i < got_byte_q.size(); i++) begin
      checks++; if (got_byte_q[i] !== want[i]) begin errors++; $display("FAIL prio_byte%0d: got %h want %h", i, got_byte_q[i], want[i]); end
      checks++; if (got_start_q[i] != k + 2 + SLOT * i) begin errors++; $display("FAIL prio_start%0d: got %0d want %0d", i, got_start_q[i], k + 2 + SLOT * i); end
      checks++; if (!got_ok_q[i]) begin errors++; $display("FAIL prio_shape%0d: frame timing bad", i); end
    end
  endtask

  task automatic test_merge();
    int k;
    bit ok;
    flush();
    k = edge_no;
    Up = 1'b1;
    tick();
    Up = 1'b0;
    repeat (10) tick();
    Right = 1'b1;
    tick();
    Right = 1'b0;
    repeat (3) tick();
    Right = 1'b1;
    tick();
    Right = 1'b0;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL merge_drain: timeout"); end
    checks++; if (got_byte_q.size() != 2) begin errors++; $display("FAIL merge_count: got %0d want 2", got_byte_q.size()); end
    if (got_byte_q.size() >= 2) begin
      checks++; if (got_byte_q[0] !== 8'h77) begin errors++; $display("FAIL merge_first: got %h want 77", got_byte_q[0]); end
      checks++; if (got_byte_q[1] !== 8'h64) begin errors++; $display("FAIL merge_second: got %h want 64", got_byte_q[1]); end
      checks++; if (got_start_q[1] != k + 2 + SLOT) begin errors++; $display("FAIL merge_start: got %0d want %0d", got_start_q[1], k + 2 + SLOT); end
    end
  endtask

  task automatic test_midframe_reset();
    flush();
    Down = 1'b1;
    tick();
    Down = 1'b0;
    repeat (16) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_inflight: busy %b want 1", busy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (scancode !== 8'h00) begin errors++; $display("FAIL midrst_scancode: got %h want 00", scancode); end
    repeat (3) tick();
    rst = 1'b0;
    repeat (100) tick();
    checks++; if (got_byte_q.size() != 0) begin errors++; $display("FAIL midrst_resume: got %0d frames want 0", got_byte_q.size()); end
    checks++; if (busy_bad != 0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy %b busy_bad %0d want idle", busy, busy_bad); end
    flush();
  endtask

  task automatic test_held_through_reset();
    int k;
    bit ok;
    flush();
    rst = 1'b1;
    Down = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (100) tick();
    checks++; if (got_byte_q.size() != 0) begin errors++; $display("FAIL held_nofire: got %0d frames want 0", got_byte_q.size()); end
    Down = 1'b0;
    tick();
    tick();
    k = edge_no;
    Down = 1'b1;
    tick();
    tick();
    Down = 1'b0;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL held_drain: timeout"); end
    checks++; if (got_byte_q.size() != 1) begin errors++; $display("FAIL held_count: got %0d want 1", got_byte_q.size()); end
    if (got_byte_q.size() >= 1) begin
      checks++; if (got_byte_q[0] !== 8'h73) begin errors++; $display("FAIL held_byte: got %h want 73", got_byte_q[0]); end
      checks++; if (got_start_q[0] != k + 2) begin errors++; $display("FAIL held_start: got %0d want %0d", got_start_q[0], k + 2); end
    end
  endtask

  task automatic test_hold_reset_btn();
    int k;
    bit ok;
    flush();
    k = edge_no;
    Reset = 1'b1;
    repeat (350) tick();
    Reset = 1'b0;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_drain: timeout"); end
    checks++; if (got_byte_q.size() != EXP_REP) begin errors++; $display("FAIL hold_count: got %0d want %0d", got_byte_q.size(), EXP_REP); end
    for (int i = 0; i < got_byte_q.size() && i < EXP_REP; i++) begin
      checks++; if (got_byte_q[i] !== 8'h72) begin errors++; $display("FAIL hold_byte%0d: got %h want 72", i, got_byte_q[i]); end
      checks++; if (got_start_q[i] != k + 2 + REP * i) begin errors++; $display("FAIL hold_start%0d: got %0d want %0d", i, got_start_q[i], k + 2 + REP * i); end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [5:0] b;
    flush();
    b = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 6; i++) if ($urandom_range(0, 99) < 4) b[i] = ~b[i];
      {userStart, Reset, Right, Left, Down, Up} = b;
      tick();
    end
    {userStart, Reset, Right, Left, Down, Up} = 6'b0;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_drain: timeout"); end
    checks++; if (got_byte_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_byte_q.size(), exp_q.size()); end
    for (int i = 0; i < got_byte_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_byte_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h want %h", i, got_byte_q[i], exp_q[i]); end
      checks++; if (got_start_q[i] != exp_start_q[i]) begin errors++; $display("FAIL rand_start%0d: got %0d want %0d", i, got_start_q[i], exp_start_q[i]); end
      checks++; if (!got_ok_q[i] || got_sc_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_frame%0d: ok %b scancode %h want clean frame with %h", i, got_ok_q[i], got_sc_q[i], exp_q[i]); end
    end
    checks++; if (busy_bad != 0 || stray_done != 0) begin errors++; $display("FAIL rand_idle: busy_bad %0d stray_done %0d want 0", busy_bad, stray_done); end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_priority();
    test_merge();
    test_midframe_reset();
    test_held_through_reset();
    test_hold_reset_btn();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
